// File: rtl/trafik_pkg.sv
// Shared light-code constants, phase encoding and monitor FSM states.
// The code constants are also used by the signal controller.
package trafik_pkg;
  localparam logic [2:0] KOD_KIRMIZI  = 3'b110;
  localparam logic [2:0] KOD_MAVI     = 3'b101;
  localparam logic [2:0] KOD_YESIL    = 3'b011;
  localparam logic [2:0] KOD_KARANLIK = 3'b111;

  typedef enum logic [1:0] {
    FAZ_YOK = 2'd0, FAZ_KIRMIZI = 2'd1, FAZ_MAVI = 2'd2, FAZ_YESIL = 2'd3
  } faz_e;

  typedef enum logic [1:0] {BASLANGIC, KIRMIZI, MAVI, YESIL} durum_e;

  function automatic faz_e durum_faz(durum_e d);
    case (d)
      KIRMIZI: return FAZ_KIRMIZI;
      MAVI:    return FAZ_MAVI;
      YESIL:   return FAZ_YESIL;
      default: return FAZ_YOK;
    endcase
  endfunction

  function automatic logic kod_yasal(logic [2:0] k);
    return (k == KOD_KIRMIZI) || (k == KOD_MAVI) || (k == KOD_YESIL) || (k == KOD_KARANLIK);
  endfunction

  // Code that legally follows the phase shown in state d.
  function automatic logic [2:0] sonraki_kod(durum_e d);
    case (d)
      KIRMIZI: return KOD_MAVI;
      MAVI:    return KOD_YESIL;
      default: return KOD_KIRMIZI;
    endcase
  endfunction

  function automatic durum_e sonraki_durum(durum_e d);
    case (d)
      KIRMIZI: return MAVI;
      MAVI:    return YESIL;
      default: return KIRMIZI;
    endcase
  endfunction
endpackage

// File: rtl/trafik_isik_izleyici_if.sv
// LED-bus monitor signal bundle: controller side (master) and monitor side (slave).
interface trafik_isik_izleyici_if #(parameter int SAYAC_W = 32);
  logic [2:0]         led_in;
  logic               hata_temizle;
  logic [1:0]         faz;
  logic               senkron;
  logic               gecis;
  logic [SAYAC_W-1:0] son_sure;
  logic               sira_hata;
  logic               sure_hata;
  logic               zaman_asimi;
  logic               kod_hata;

  modport master (output led_in, hata_temizle,
                  input  faz, senkron, gecis, son_sure, sira_hata, sure_hata, zaman_asimi, kod_hata);
  modport slave  (input  led_in, hata_temizle,
                  output faz, senkron, gecis, son_sure, sira_hata, sure_hata, zaman_asimi, kod_hata);
endinterface

// File: rtl/kod_filtre.sv
// Two-flop input register plus stability filter; a new code is accepted after
// FILTRE consecutive identical samples. Latency is fixed, so dwells are preserved.
module kod_filtre #(
  parameter int FILTRE = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [2:0] kod_in,
  output logic [2:0] kod,
  output logic       degisti
);
  logic [2:0] s1_q, s1_d, s2_q, s2_d, kod_q, kod_d, aday_q, aday_d;
  logic [7:0] say_q, say_d;
  logic       degisti_q, degisti_d;

  always_comb begin
    s1_d      = kod_in;
    s2_d      = s1_q;
    kod_d     = kod_q;
    aday_d    = aday_q;
    say_d     = say_q;
    degisti_d = 1'b0;
    if (s2_q == kod_q) begin
      say_d = 8'd0;
    end else begin
      // Any change of candidate restarts the stability window.
      if (s2_q == aday_q && say_q != 8'd0) say_d = say_q + 8'd1;
      else begin
        aday_d = s2_q;
        say_d  = 8'd1;
      end
      if (say_d == 8'(FILTRE)) begin
        kod_d     = s2_q;
        say_d     = 8'd0;
        degisti_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1_q      <= 3'b111;
      s2_q      <= 3'b111;
      kod_q     <= 3'b111;
      aday_q    <= 3'b111;
      say_q     <= 8'd0;
      degisti_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      kod_q     <= kod_d;
      aday_q    <= aday_d;
      say_q     <= say_d;
      degisti_q <= degisti_d;
    end
  end

  assign kod     = kod_q;
  assign degisti = degisti_q;
endmodule

// File: rtl/trafik_isik_izleyici.sv
// Passive traffic-light LED monitor: phase decode, dwell measurement,
// order / duration / timeout / code-legality checks with sticky flags.
module trafik_isik_izleyici import trafik_pkg::*; #(
  parameter int unsigned KIRMIZI_SURE = 240_000_000,
  parameter int unsigned MAVI_SURE    = 48_000_000,
  parameter int unsigned YESIL_SURE   = 120_000_000,
  parameter int unsigned TOLERANS     = 16,
  parameter int          FILTRE       = 4,
  parameter int          SAYAC_W      = 32
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  trafik_isik_izleyici_if.slave  bus
);
  localparam logic [SAYAC_W:0] TOL = (SAYAC_W+1)'(TOLERANS);

  logic [2:0] kod;
  logic       degisti;

  kod_filtre #(.FILTRE(FILTRE)) u_filtre (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .kod_in  (bus.led_in),
    .kod     (kod),
    .degisti (degisti)
  );

  durum_e             durum_q, durum_d;
  logic [SAYAC_W-1:0] sayac_q, sayac_d, son_sure_q, son_sure_d, sinir;
  logic [SAYAC_W:0]   olcu, beklenen;
  logic gecis_q, gecis_d, senkron_q, senkron_d, ilk_q, ilk_d, zamanli_q, zamanli_d;
  logic sira_q, sira_d, sure_q, sure_d, zaman_q, zaman_d, kodh_q, kodh_d;
  logic sira_set, sure_set, zaman_set, kod_set, disarida;

  // Dwell window of the current phase, compared one bit wider so nothing wraps.
  always_comb begin
    case (durum_q)
      KIRMIZI: beklenen = (SAYAC_W+1)'(KIRMIZI_SURE);
      MAVI:    beklenen = (SAYAC_W+1)'(MAVI_SURE);
      YESIL:   beklenen = (SAYAC_W+1)'(YESIL_SURE);
      default: beklenen = '0;
    endcase
    olcu     = {1'b0, sayac_q};
    sinir    = beklenen[SAYAC_W-1:0] + SAYAC_W'(TOLERANS + 1);
    disarida = (olcu > beklenen + TOL) || (olcu + TOL < beklenen);
  end

  always_comb begin
    sayac_d    = degisti ? SAYAC_W'(1) : (&sayac_q ? sayac_q : sayac_q + SAYAC_W'(1));
    son_sure_d = degisti ? sayac_q : son_sure_q;
    gecis_d    = degisti;
    durum_d    = durum_q;
    senkron_d  = senkron_q;
    zamanli_d  = zamanli_q;
    ilk_d      = ilk_q & ~degisti;
    sira_set   = 1'b0;
    sure_set   = 1'b0;
    zaman_set  = 1'b0;
    kod_set    = 1'b0;
    if (degisti) begin
      if (!kod_yasal(kod)) begin
        kod_set   = 1'b1;
        durum_d   = BASLANGIC;
        senkron_d = 1'b0;
        zamanli_d = 1'b0;
      end else if (durum_q == BASLANGIC) begin
        // The red seen straight out of reset is a partial phase: never timed.
        if (kod == KOD_KIRMIZI) begin
          durum_d   = KIRMIZI;
          zamanli_d = ~ilk_q;
        end
      end else if (kod == sonraki_kod(durum_q)) begin
        durum_d   = sonraki_durum(durum_q);
        sure_set  = zamanli_q & disarida;
        zamanli_d = 1'b1;
        if (durum_q == YESIL) senkron_d = 1'b1;
      end else begin
        sira_set  = 1'b1;
        durum_d   = BASLANGIC;
        senkron_d = 1'b0;
        zamanli_d = 1'b0;
      end
    end else if (zamanli_q && durum_q != BASLANGIC && sayac_q == sinir) begin
      zaman_set = 1'b1;
    end
    sira_d  = (sira_q  & ~bus.hata_temizle) | sira_set;
    sure_d  = (sure_q  & ~bus.hata_temizle) | sure_set;
    zaman_d = (zaman_q & ~bus.hata_temizle) | zaman_set;
    kodh_d  = (kodh_q  & ~bus.hata_temizle) | kod_set;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      durum_q    <= BASLANGIC;
      sayac_q    <= '0;
      son_sure_q <= '0;
      gecis_q    <= 1'b0;
      senkron_q  <= 1'b0;
      ilk_q      <= 1'b1;
      zamanli_q  <= 1'b0;
      sira_q     <= 1'b0;
      sure_q     <= 1'b0;
      zaman_q    <= 1'b0;
      kodh_q     <= 1'b0;
    end else begin
      durum_q    <= durum_d;
      sayac_q    <= sayac_d;
      son_sure_q <= son_sure_d;
      gecis_q    <= gecis_d;
      senkron_q  <= senkron_d;
      ilk_q      <= ilk_d;
      zamanli_q  <= zamanli_d;
      sira_q     <= sira_d;
      sure_q     <= sure_d;
      zaman_q    <= zaman_d;
      kodh_q     <= kodh_d;
    end
  end

  assign bus.faz         = durum_faz(durum_q);
  assign bus.senkron     = senkron_q;
  assign bus.gecis       = gecis_q;
  assign bus.son_sure    = son_sure_q;
  assign bus.sira_hata   = sira_q;
  assign bus.sure_hata   = sure_q;
  assign bus.zaman_asimi = zaman_q;
  assign bus.kod_hata    = kodh_q;
endmodule

// File: tb/tb_trafik_isik_izleyici.sv
// Directed bench for the traffic-light monitor (red 100, blue 20, green 50, tol 2, filter 4).
module tb_trafik_isik_izleyici;
  localparam int SW = 32;
  localparam logic [2:0] R = 3'b110, B = 3'b101, G = 3'b011, D = 3'b111;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  trafik_isik_izleyici_if #(.SAYAC_W(SW)) bus ();

  trafik_isik_izleyici #(
    .KIRMIZI_SURE(100), .MAVI_SURE(20), .YESIL_SURE(50),
    .TOLERANS(2), .FILTRE(4), .SAYAC_W(SW)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  logic [SW-1:0] sq[$];
  logic [1:0]    fq[$];

  always @(negedge sys_clk)
    if (bus.gecis === 1'b1) begin
      sq.push_back(bus.son_sure);
      fq.push_back(bus.faz);
    end

  function automatic logic [3:0] bayrak();
    return {bus.sira_hata, bus.sure_hata, bus.zaman_asimi, bus.kod_hata};
  endfunction

  task automatic hold(input logic [2:0] k, input int n);
    bus.led_in = k;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic bekle_gecis(output int n);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (bus.gecis !== 1'b1 && n < 20);
  endtask

  task automatic rst_pulse();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    bus.led_in = D;
    bus.hata_temizle = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge sys_clk);
    checks++;
    if ({bus.faz, bus.senkron, bus.gecis, bayrak()} !== 8'd0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0", {bus.faz, bus.senkron, bus.gecis, bayrak()});
    end
    checks++;
    if (bus.son_sure !== '0) begin
      errors++; $display("FAIL reset_son_sure: got %0d expected 0", bus.son_sure);
    end
    sys_rst = 1'b0;
  endtask

  task automatic test_legal_cycle();
    logic [SW-1:0] es[6] = '{100, 20, 50, 100, 20, 50};
    logic [1:0]    ef[6] = '{2, 3, 1, 2, 3, 1};
    rst_pulse();
    hold(R, 100);
    sq.delete(); fq.delete();
    hold(B, 20); hold(G, 50);
    checks++;
    if (bus.senkron !== 1'b0) begin
      errors++; $display("FAIL legal_senkron_early: got %b expected 0", bus.senkron);
    end
    hold(R, 100);
    checks++;
    if (bus.senkron !== 1'b1) begin
      errors++; $display("FAIL legal_senkron: got %b expected 1", bus.senkron);
    end
    hold(B, 20); hold(G, 50); hold(R, 100);
    checks++;
    if (sq.size() !== 6) begin
      errors++; $display("FAIL legal_gecis_count: got %0d expected 6", sq.size());
    end else
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (sq[i] !== es[i] || fq[i] !== ef[i]) begin
          errors++; $display("FAIL legal_event%0d: got son_sure=%0d faz=%0d expected %0d/%0d", i, sq[i], fq[i], es[i], ef[i]);
        end
      end
    checks++;
    if (bayrak() !== 4'b0000) begin
      errors++; $display("FAIL legal_flags: got %b expected 0000", bayrak());
    end
  endtask

  task automatic test_tolerance();
    int n;
    rst_pulse();
    hold(R, 100);
    sq.delete(); fq.delete();
    hold(B, 22); hold(G, 50);
    checks++;
    if (sq.size() !== 2 || sq[1] !== 22 || bus.sure_hata !== 1'b0) begin
      errors++; $display("FAIL tol_22: got n=%0d sure_hata=%b expected 2 events, 22, 0", sq.size(), bus.sure_hata);
    end
    hold(R, 100); hold(B, 23);
    bus.led_in = G;
    bekle_gecis(n);
    checks++;
    if (n !== 7) begin
      errors++; $display("FAIL tol_latency: got %0d expected 7", n);
    end
    checks++;
    if (bus.son_sure !== 23 || bus.sure_hata !== 1'b1) begin
      errors++; $display("FAIL tol_23: got son_sure=%0d sure_hata=%b expected 23/1", bus.son_sure, bus.sure_hata);
    end
    @(negedge sys_clk);
    checks++;
    if (bus.gecis !== 1'b0) begin
      errors++; $display("FAIL gecis_width: got %b expected 0", bus.gecis);
    end
  endtask

  task automatic test_order();
    int n;
    rst_pulse();
    hold(R, 40);
    bus.led_in = G;
    bekle_gecis(n);
    checks++;
    if ({bus.sira_hata, bus.senkron, bus.faz, bus.sure_hata} !== 5'b10000) begin
      errors++; $display("FAIL order_err: got %b expected 10000", {bus.sira_hata, bus.senkron, bus.faz, bus.sure_hata});
    end
    hold(G, 30);
    bus.led_in = R;
    bekle_gecis(n);
    checks++;
    if (bus.faz !== 2'd1 || bus.sure_hata !== 1'b0) begin
      errors++; $display("FAIL order_resync: got faz=%0d sure_hata=%b expected 1/0", bus.faz, bus.sure_hata);
    end
    hold(R, 100 - n);
    bus.led_in = B;
    bekle_gecis(n);
    checks++;
    if (bus.son_sure !== 100 || bus.faz !== 2'd2 || bus.sure_hata !== 1'b0) begin
      errors++; $display("FAIL order_next: got son_sure=%0d faz=%0d sure_hata=%b expected 100/2/0", bus.son_sure, bus.faz, bus.sure_hata);
    end
  endtask

  task automatic test_glitch_illegal();
    int m;
    rst_pulse();
    hold(R, 30);
    sq.delete(); fq.delete();
    hold(3'b100, 3); hold(R, 30);
    checks++;
    if (sq.size() !== 0 || bayrak() !== 4'b0000 || bus.faz !== 2'd1) begin
      errors++; $display("FAIL glitch: got events=%0d flags=%b faz=%0d expected 0/0000/1", sq.size(), bayrak(), bus.faz);
    end
    hold(3'b000, 4);
    bus.led_in = R;
    m = 0;
    do begin @(negedge sys_clk); m++; end while (bus.kod_hata !== 1'b1 && m < 20);
    checks++;
    if (m !== 3 || bus.faz !== 2'd0 || bus.gecis !== 1'b1) begin
      errors++; $display("FAIL illegal_code: got wait=%0d faz=%0d gecis=%b expected 3/0/1", m, bus.faz, bus.gecis);
    end
    m = 0;
    do begin @(negedge sys_clk); m++; end while (bus.faz !== 2'd1 && m < 20);
    checks++;
    if (bus.faz !== 2'd1) begin
      errors++; $display("FAIL illegal_recover: got faz=%0d expected 1", bus.faz);
    end
  endtask

  task automatic test_stuck();
    int n, c;
    rst_pulse();
    hold(R, 100); hold(B, 20);
    bus.led_in = G;
    bekle_gecis(n);
    c = 0;
    do begin @(negedge sys_clk); c++; end while (bus.zaman_asimi !== 1'b1 && c < 80);
    checks++;
    if (c !== 53 || bus.sure_hata !== 1'b0) begin
      errors++; $display("FAIL stuck_timeout: got cycles=%0d sure_hata=%b expected 53/0", c, bus.sure_hata);
    end
    repeat (60 - n - c) @(negedge sys_clk);
    bus.led_in = R;
    bekle_gecis(n);
    checks++;
    if (bus.son_sure !== 60 || bus.sure_hata !== 1'b1 || bus.zaman_asimi !== 1'b1) begin
      errors++; $display("FAIL stuck_exit: got son_sure=%0d sure=%b zaman=%b expected 60/1/1", bus.son_sure, bus.sure_hata, bus.zaman_asimi);
    end
  endtask

  task automatic test_clear();
    rst_pulse();
    hold(R, 30); hold(3'b010, 5); hold(R, 20); hold(G, 20);
    checks++;
    if (bayrak() !== 4'b1001) begin
      errors++; $display("FAIL clear_setup: got %b expected 1001", bayrak());
    end
    bus.hata_temizle = 1'b1;
    @(negedge sys_clk);
    bus.hata_temizle = 1'b0;
    checks++;
    if (bayrak() !== 4'b0000) begin
      errors++; $display("FAIL clear_flags: got %b expected 0000", bayrak());
    end
    hold(3'b001, 4);
    bus.led_in = G;
    repeat (2) @(negedge sys_clk);
    bus.hata_temizle = 1'b1;
    @(negedge sys_clk);
    bus.hata_temizle = 1'b0;
    checks++;
    if (bayrak() !== 4'b0001) begin
      errors++; $display("FAIL clear_set_wins: got %b expected 0001", bayrak());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    rst_pulse();
    hold(R, 100); hold(B, 23); hold(G, 50); hold(R, 30);
    checks++;
    if (bus.senkron !== 1'b1 || bus.sure_hata !== 1'b1 || bus.faz !== 2'd1) begin
      errors++; $display("FAIL rstmid_setup: got senkron=%b sure=%b faz=%0d expected 1/1/1", bus.senkron, bus.sure_hata, bus.faz);
    end
    sys_rst = 1'b1;
    #1;
    checks++;
    if ({bus.faz, bus.senkron, bus.gecis, bayrak()} !== 8'd0 || bus.son_sure !== '0) begin
      errors++; $display("FAIL rstmid_immediate: got %b son_sure=%0d expected 0", {bus.faz, bus.senkron, bus.gecis, bayrak()}, bus.son_sure);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    hold(R, 40);
    bus.led_in = B;
    bekle_gecis(n);
    checks++;
    if (bus.son_sure !== 40 || bus.sure_hata !== 1'b0 || bus.faz !== 2'd2) begin
      errors++; $display("FAIL rstmid_untimed: got son_sure=%0d sure=%b faz=%0d expected 40/0/2", bus.son_sure, bus.sure_hata, bus.faz);
    end
  endtask

  initial begin
    bus.led_in = D;
    bus.hata_temizle = 1'b0;
    test_reset();
    test_legal_cycle();
    test_tolerance();
    test_order();
    test_glitch_illegal();
    test_stuck();
    test_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
